dprintf_req_arbiter: RTL and testbench

DPRINTF_REQ_ARBITER -- requirements
Module: dprintf_req_arbiter

---
 rtl/dprintf_req_arbiter_if.sv | 55 +++++
 rtl/dprintf_req_arbiter.sv | 118 +++++++++++
 tb/tb_dprintf_req_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dprintf_req_arbiter_if.sv
// Handshake bundle between four dprintf requesters, the arbiter and the shared
// dprintf consumer.
//   slave  : arbiter view (requests and consumer ack in; grant, payload, acks out)
//   master : environment view (requesters and consumer), directions mirrored
interface dprintf_req_arbiter_if;
   logic        req_in_0__valid;
   logic [15:0] req_in_0__address;
   logic [63:0] req_in_0__data_0, req_in_0__data_1, req_in_0__data_2, req_in_0__data_3;
   logic        req_in_1__valid;
   logic [15:0] req_in_1__address;
   logic [63:0] req_in_1__data_0, req_in_1__data_1, req_in_1__data_2, req_in_1__data_3;
   logic        req_in_2__valid;
   logic [15:0] req_in_2__address;
   logic [63:0] req_in_2__data_0, req_in_2__data_1, req_in_2__data_2, req_in_2__data_3;
   logic        req_in_3__valid;
   logic [15:0] req_in_3__address;
   logic [63:0] req_in_3__data_0, req_in_3__data_1, req_in_3__data_2, req_in_3__data_3;

   logic [3:0]  ack_in;
   logic        req_out__valid;
   logic [15:0] req_out__address;
   logic [63:0] req_out__data_0, req_out__data_1, req_out__data_2, req_out__data_3;
   logic [1:0]  req_out__source;
   logic        ack_out;

   modport slave (
      input  req_in_0__valid, req_in_0__address,
             req_in_0__data_0, req_in_0__data_1, req_in_0__data_2, req_in_0__data_3,
      input  req_in_1__valid, req_in_1__address,
             req_in_1__data_0, req_in_1__data_1, req_in_1__data_2, req_in_1__data_3,
      input  req_in_2__valid, req_in_2__address,
             req_in_2__data_0, req_in_2__data_1, req_in_2__data_2, req_in_2__data_3,
      input  req_in_3__valid, req_in_3__address,
             req_in_3__data_0, req_in_3__data_1, req_in_3__data_2, req_in_3__data_3,
      input  ack_out,
      output ack_in, req_out__valid, req_out__address,
             req_out__data_0, req_out__data_1, req_out__data_2, req_out__data_3,
             req_out__source
   );

   modport master (
      output req_in_0__valid, req_in_0__address,
             req_in_0__data_0, req_in_0__data_1, req_in_0__data_2, req_in_0__data_3,
      output req_in_1__valid, req_in_1__address,
             req_in_1__data_0, req_in_1__data_1, req_in_1__data_2, req_in_1__data_3,
      output req_in_2__valid, req_in_2__address,
             req_in_2__data_0, req_in_2__data_1, req_in_2__data_2, req_in_2__data_3,
      output req_in_3__valid, req_in_3__address,
             req_in_3__data_0, req_in_3__data_1, req_in_3__data_2, req_in_3__data_3,
      output ack_out,
      input  ack_in, req_out__valid, req_out__address,
             req_out__data_0, req_out__data_1, req_out__data_2, req_out__data_3,
             req_out__source
   );
endinterface

// File: rtl/dprintf_req_arbiter.sv
// Round-robin arbiter funnelling four dprintf requesters into one consumer.
// One request is outstanding at a time; the granted payload is latched and
// held until the consumer acks, then the requester gets a one-cycle ack.
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : dprintf_req_arbiter_if.slave (requests, consumer handshake)
//
// state   | meaning
// IDLE    | no request outstanding; grant first valid at/after rr_ptr
// PRESENT | latched request on req_out, waiting for ack_out
// RELEASE | ack_in pulse cycle; requester valid not sampled here
module dprintf_req_arbiter (
   input logic                  clk,
   input logic                  reset_n,
   dprintf_req_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

   state_t      state;
   logic [1:0]  rr_ptr;
   logic [3:0]  valid_vec;
   logic [15:0] addr_arr [4];
   logic [63:0] data_arr [4][4];
   logic        grant_found;
   logic [1:0]  grant_idx;

   logic        out_valid;
   logic [3:0]  ack_q;
   logic [15:0] addr_q;
   logic [63:0] data_q [4];
   logic [1:0]  src_q;

   assign valid_vec = {bus.req_in_3__valid, bus.req_in_2__valid,
                       bus.req_in_1__valid, bus.req_in_0__valid};

   assign addr_arr[0] = bus.req_in_0__address;
   assign addr_arr[1] = bus.req_in_1__address;
   assign addr_arr[2] = bus.req_in_2__address;
   assign addr_arr[3] = bus.req_in_3__address;

   assign data_arr[0][0] = bus.req_in_0__data_0;
   assign data_arr[0][1] = bus.req_in_0__data_1;
   assign data_arr[0][2] = bus.req_in_0__data_2;
   assign data_arr[0][3] = bus.req_in_0__data_3;
   assign data_arr[1][0] = bus.req_in_1__data_0;
   assign data_arr[1][1] = bus.req_in_1__data_1;
   assign data_arr[1][2] = bus.req_in_1__data_2;
   assign data_arr[1][3] = bus.req_in_1__data_3;
   assign data_arr[2][0] = bus.req_in_2__data_0;
   assign data_arr[2][1] = bus.req_in_2__data_1;
   assign data_arr[2][2] = bus.req_in_2__data_2;
   assign data_arr[2][3] = bus.req_in_2__data_3;
   assign data_arr[3][0] = bus.req_in_3__data_0;
   assign data_arr[3][1] = bus.req_in_3__data_1;
   assign data_arr[3][2] = bus.req_in_3__data_2;
   assign data_arr[3][3] = bus.req_in_3__data_3;

   // Scan cyclically from rr_ptr; 2-bit addition wraps 3 -> 0 naturally.
   always_comb begin
      logic [1:0] cand;
      grant_found = 1'b0;
      grant_idx   = rr_ptr;
      cand        = rr_ptr;
      for (int i = 0; i < 4; i++) begin
         cand = rr_ptr + 2'(i);
         if (!grant_found && valid_vec[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         out_valid <= 1'b0;
         ack_q     <= '0;
         src_q     <= '0;
         addr_q    <= '0;
         for (int i = 0; i < 4; i++) data_q[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  out_valid <= 1'b1;
                  src_q     <= grant_idx;
                  addr_q    <= addr_arr[grant_idx];
                  for (int i = 0; i < 4; i++) data_q[i] <= data_arr[grant_idx][i];
                  state     <= PRESENT;
               end
            end
            PRESENT: begin
               if (bus.ack_out) begin
                  out_valid <= 1'b0;
                  ack_q     <= 4'b0001 << src_q;
                  rr_ptr    <= src_q + 2'd1;
                  state     <= RELEASE;
               end
            end
            RELEASE: begin
               ack_q <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_out__valid   = out_valid;
   assign bus.ack_in           = ack_q;
   assign bus.req_out__source  = src_q;
   assign bus.req_out__address = addr_q;
   assign bus.req_out__data_0  = data_q[0];
   assign bus.req_out__data_1  = data_q[1];
   assign bus.req_out__data_2  = data_q[2];
   assign bus.req_out__data_3  = data_q[3];
endmodule

// File: tb/tb_dprintf_req_arbiter.sv
// Self-checking bench for dprintf_req_arbiter: a transaction-level model of
// the arbiter is compared against the DUT on every falling edge, and directed
// scenarios add literal expectations.
module tb_dprintf_req_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  r_valid;
   logic [15:0] r_addr [4];
   logic [63:0] r_data [4][4];
   logic        ack_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   bit auto_ack  = 1'b0;
   bit auto_drop = 1'b0;
   int g_src[$];
   int g_cyc[$];

   dprintf_req_arbiter_if bus ();

   assign bus.req_in_0__valid   = r_valid[0];
   assign bus.req_in_0__address = r_addr[0];
   assign bus.req_in_0__data_0  = r_data[0][0];
   assign bus.req_in_0__data_1  = r_data[0][1];
   assign bus.req_in_0__data_2  = r_data[0][2];
   assign bus.req_in_0__data_3  = r_data[0][3];
   assign bus.req_in_1__valid   = r_valid[1];
   assign bus.req_in_1__address = r_addr[1];
   assign bus.req_in_1__data_0  = r_data[1][0];
   assign bus.req_in_1__data_1  = r_data[1][1];
   assign bus.req_in_1__data_2  = r_data[1][2];
   assign bus.req_in_1__data_3  = r_data[1][3];
   assign bus.req_in_2__valid   = r_valid[2];
   assign bus.req_in_2__address = r_addr[2];
   assign bus.req_in_2__data_0  = r_data[2][0];
   assign bus.req_in_2__data_1  = r_data[2][1];
   assign bus.req_in_2__data_2  = r_data[2][2];
   assign bus.req_in_2__data_3  = r_data[2][3];
   assign bus.req_in_3__valid   = r_valid[3];
   assign bus.req_in_3__address = r_addr[3];
   assign bus.req_in_3__data_0  = r_data[3][0];
   assign bus.req_in_3__data_1  = r_data[3][1];
   assign bus.req_in_3__data_2  = r_data[3][2];
   assign bus.req_in_3__data_3  = r_data[3][3];
   assign bus.ack_out           = ack_out;

   dprintf_req_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Transaction-level model: an outstanding request record plus a one-cycle
   // acknowledge slot. Grant search uses modulo arithmetic over requester ids.
   bit          m_busy = 1'b0;
   bit          m_ack_slot = 1'b0;
   int          m_ptr = 0;
   int          m_src = 0;
   logic [15:0] m_addr = '0;
   logic [63:0] m_data [4] = '{default: '0};
   logic [3:0]  m_ack = '0;

   always @(posedge clk or negedge reset_n) begin
      int  c;
      bit  done;
      if (!reset_n) begin
         m_busy = 1'b0; m_ack_slot = 1'b0; m_ptr = 0; m_src = 0;
         m_addr = '0; m_ack = '0;
         for (int j = 0; j < 4; j++) m_data[j] = '0;
      end else if (m_ack_slot) begin
         m_ack_slot = 1'b0;
         m_ack = '0;
      end else if (m_busy) begin
         if (ack_out) begin
            m_busy = 1'b0;
            m_ack = 4'(1 << m_src);
            m_ptr = (m_src + 1) % 4;
            m_ack_slot = 1'b1;
         end
      end else begin
         done = 1'b0;
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (!done && r_valid[c]) begin
               done = 1'b1;
               m_busy = 1'b1;
               m_src = c;
               m_addr = r_addr[c];
               for (int j = 0; j < 4; j++) m_data[j] = r_data[c][j];
            end
         end
      end
   end

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      chk("valid",   bus.req_out__valid,   m_busy);
      chk("ack_in",  bus.ack_in,           m_ack);
      chk("source",  bus.req_out__source,  m_src);
      chk("address", bus.req_out__address, m_addr);
      chk("data_0",  bus.req_out__data_0,  m_data[0]);
      chk("data_1",  bus.req_out__data_1,  m_data[1]);
      chk("data_2",  bus.req_out__data_2,  m_data[2]);
      chk("data_3",  bus.req_out__data_3,  m_data[3]);
   end

   always @(negedge clk) begin
      if (bus.ack_in != 4'b0000) begin
         chk("ack_onehot", $countones(bus.ack_in), 1);
         for (int i = 0; i < 4; i++)
            if (bus.ack_in[i]) g_src.push_back(i);
         g_cyc.push_back(cycle);
      end
   end

   // Inputs change 1 time unit after the falling edge, well away from posedge.
   task automatic step();
      @(negedge clk);
      #1;
      if (auto_ack) ack_out = bus.req_out__valid;
      if (auto_drop)
         for (int i = 0; i < 4; i++)
            if (bus.ack_in[i]) r_valid[i] = 1'b0;
   endtask

   task automatic set_req(input int n, input logic [15:0] a, input logic [63:0] d0);
      r_addr[n] = a;
      r_data[n][0] = d0;
      r_data[n][1] = d0 + 64'h100;
      r_data[n][2] = d0 + 64'h200;
      r_data[n][3] = d0 + 64'h300;
      r_valid[n] = 1'b1;
   endtask

   initial begin
      r_valid = '0;
      ack_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
         r_addr[i] = '0;
         for (int j = 0; j < 4; j++) r_data[i][j] = '0;
      end

      // reset values
      step();
      chk("rst_valid",  bus.req_out__valid, 1'b0);
      chk("rst_ack",    bus.ack_in, 4'b0000);
      chk("rst_source", bus.req_out__source, 2'd0);
      chk("rst_addr",   bus.req_out__address, 16'h0000);
      step();
      reset_n = 1'b1;
      step();

      // single request from requester 2
      r_addr[2] = 16'h0050;
      r_data[2][0] = 64'h87;
      r_valid[2] = 1'b1;
      step();
      chk("single_valid", bus.req_out__valid, 1'b1);
      chk("single_src",   bus.req_out__source, 2'd2);
      chk("single_addr",  bus.req_out__address, 16'h0050);
      chk("single_data0", bus.req_out__data_0, 64'h87);
      ack_out = 1'b1;
      step();
      ack_out = 1'b0;
      chk("single_ack", bus.ack_in, 4'b0100);
      chk("single_valid_clr", bus.req_out__valid, 1'b0);
      r_valid[2] = 1'b0;
      step();
      chk("single_ack_clr", bus.ack_in, 4'b0000);
      chk("single_ptr", m_ptr, 3);

      // wrap: pointer at 3, requesters 0 and 3 pending
      g_src.delete(); g_cyc.delete();
      set_req(0, 16'h1000, 64'hA000);
      set_req(3, 16'h3000, 64'hD000);
      auto_ack = 1'b1; auto_drop = 1'b1;
      repeat (10) step();
      chk("wrap_count",  g_src.size(), 2);
      chk("wrap_first",  (g_src.size() > 0) ? g_src[0] : -1, 3);
      chk("wrap_second", (g_src.size() > 1) ? g_src[1] : -1, 0);

      // fairness: fresh reset, all four continuously valid
      step(); reset_n = 1'b0;
      step(); reset_n = 1'b1;
      g_src.delete(); g_cyc.delete();
      auto_drop = 1'b0;
      set_req(0, 16'h0100, 64'h10);
      set_req(1, 16'h0101, 64'h11);
      set_req(2, 16'h0102, 64'h12);
      set_req(3, 16'h0103, 64'h13);
      repeat (18) step();
      r_valid = '0;
      repeat (4) step();
      chk("rr_count_ge5", g_src.size() >= 5, 1'b1);
      for (int i = 0; i < 5; i++)
         chk($sformatf("rr_seq%0d", i), (g_src.size() > i) ? g_src[i] : -1, i % 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr_period%0d", i),
             (g_cyc.size() > i + 1) ? g_cyc[i + 1] - g_cyc[i] : -1, 3);

      // stalled consumer; requester 1 payload churns while presented
      auto_ack = 1'b0;
      ack_out = 1'b0;
      set_req(1, 16'hBEEF, 64'h1111_2222_3333_4444);
      for (int i = 0; i < 100; i++) begin
         step();
         chk("stall_valid", bus.req_out__valid, 1'b1);
         chk("stall_addr",  bus.req_out__address, 16'hBEEF);
         chk("stall_data0", bus.req_out__data_0, 64'h1111_2222_3333_4444);
         chk("stall_ack",   bus.ack_in, 4'b0000);
         r_addr[1] = 16'($urandom);
         r_data[1][0] = {$urandom, $urandom};
      end
      ack_out = 1'b1;
      step();
      ack_out = 1'b0;
      chk("stall_ack_pulse", bus.ack_in, 4'b0010);
      r_valid[1] = 1'b0;
      step();

      // reset while presenting source 1
      set_req(1, 16'h0111, 64'h1);
      step();
      chk("rstmid_src", bus.req_out__source, 2'd1);
      chk("rstmid_valid", bus.req_out__valid, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_async_valid", bus.req_out__valid, 1'b0);
      chk("rstmid_async_ack",   bus.ack_in, 4'b0000);
      chk("rstmid_async_src",   bus.req_out__source, 2'd0);
      step();
      set_req(3, 16'h0333, 64'h3);
      step();
      reset_n = 1'b1;
      g_src.delete(); g_cyc.delete();
      auto_ack = 1'b1; auto_drop = 1'b1;
      repeat (10) step();
      chk("rstmid_first",  (g_src.size() > 0) ? g_src[0] : -1, 1);
      chk("rstmid_second", (g_src.size() > 1) ? g_src[1] : -1, 3);

      // spurious consumer ack in IDLE
      auto_ack = 1'b0; auto_drop = 1'b0;
      r_valid = '0;
      ack_out = 1'b0;
      step(); step();
      ack_out = 1'b1;
      step();
      ack_out = 1'b0;
      chk("spur_ack0", bus.ack_in, 4'b0000);
      step();
      chk("spur_ack1",  bus.ack_in, 4'b0000);
      chk("spur_valid", bus.req_out__valid, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
